// File: rtl/mux_4to1.sv
// 4:1 selector with a zero-latency combinational output, an enable-captured
// registered copy, and per-input saturating selection counters that can be
// read back for debug.
module mux_4to1 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             out_vld,
    input  logic             cnt_clr,
    input  logic [1:0]       cnt_rd_sel,
    output logic [CNT_W-1:0] cnt_rd_data
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt [4];

    // Combinational selection; every sel code maps to an input, so no default arm.
    always_comb begin
        out = in0;
        case (sel)
            2'b00: out = in0;
            2'b01: out = in1;
            2'b10: out = in2;
            2'b11: out = in3;
        endcase
    end

    // Registered copy of the selection, loaded under en; out_vld echoes en one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            out_vld <= 1'b0;
        end else begin
            out_vld <= en;
            if (en) begin
                out_q <= out;
            end
        end
    end

    // Selection counters: reset and clear win over a same-cycle increment; saturate at max.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else if (en && (cnt[sel] != CNT_MAX)) begin
            cnt[sel] <= cnt[sel] + CNT_ONE;
        end
    end

    // Debug read port reflects post-edge counter state.
    assign cnt_rd_data = cnt[cnt_rd_sel];

endmodule

// File: tb/tb_mux_4to1.sv
// Directed and random checks of mux_4to1. u_dut1 is the narrow build
// (WIDTH=1, CNT_W=2) used for walks, registered path, saturation and
// priority; u_dut8 (WIDTH=8, CNT_W=8) is driven with random traffic.
module tb_mux_4to1;

    logic clk;

    logic       rst1, en1, cnt_clr1;
    logic [1:0] sel1, rd_sel1;
    logic       a0, a1, a2, a3;
    logic       out1, out_q1, out_vld1;
    logic [1:0] cnt1;

    logic       rst8, en8, cnt_clr8;
    logic [1:0] sel8, rd_sel8;
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] out8, out_q8;
    logic       out_vld8;
    logic [7:0] cnt8;

    int tests;
    int fails;

    mux_4to1 #(.WIDTH(1), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst1), .en(en1), .sel(sel1),
        .in0(a0), .in1(a1), .in2(a2), .in3(a3),
        .out(out1), .out_q(out_q1), .out_vld(out_vld1),
        .cnt_clr(cnt_clr1), .cnt_rd_sel(rd_sel1), .cnt_rd_data(cnt1)
    );

    mux_4to1 #(.WIDTH(8), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst(rst8), .en(en8), .sel(sel8),
        .in0(b0), .in1(b1), .in2(b2), .in3(b3),
        .out(out8), .out_q(out_q8), .out_vld(out_vld8),
        .cnt_clr(cnt_clr8), .cnt_rd_sel(rd_sel8), .cnt_rd_data(cnt8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        rst1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (out_q1 !== 1'b0) begin
            fails++;
            $display("FAIL reset_out_q got %0b exp 0", out_q1);
        end
        tests++;
        if (out_vld1 !== 1'b0) begin
            fails++;
            $display("FAIL reset_out_vld got %0b exp 0", out_vld1);
        end
        for (int i = 0; i < 4; i++) begin
            rd_sel1 = 2'(i);
            #1;
            tests++;
            if (cnt1 !== 2'd0) begin
                fails++;
                $display("FAIL reset_cnt%0d got %0d exp 0", i, cnt1);
            end
        end
        rst1 = 1'b0;
    endtask

    task automatic test_onehot();
        logic [3:0] pat [4];
        pat[0] = 4'b1000; pat[1] = 4'b0100; pat[2] = 4'b0010; pat[3] = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            sel1 = 2'(i);
            {a0, a1, a2, a3} = pat[i];
            #10;
            tests++;
            if (out1 !== 1'b1) begin
                fails++;
                $display("FAIL onehot_sel%0d got %0b exp 1", i, out1);
            end
        end
    endtask

    task automatic test_inverse();
        logic [3:0] pat [4];
        pat[0] = 4'b0111; pat[1] = 4'b1011; pat[2] = 4'b1101; pat[3] = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            sel1 = 2'(i);
            {a0, a1, a2, a3} = pat[i];
            #10;
            tests++;
            if (out1 !== 1'b0) begin
                fails++;
                $display("FAIL inverse_sel%0d got %0b exp 0", i, out1);
            end
        end
        // sel=11 selects in3=0; toggle unselected in0
        a0 = ~a0;
        #1;
        tests++;
        if (out1 !== 1'b0) begin
            fails++;
            $display("FAIL inverse_toggle_unselected got %0b exp 0", out1);
        end
    endtask

    task automatic test_registered();
        @(negedge clk);
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        tests++;
        if (out_q1 !== 1'b0 || out_vld1 !== 1'b0) begin
            fails++;
            $display("FAIL reg_after_rst got q=%0b vld=%0b exp q=0 vld=0", out_q1, out_vld1);
        end
        en1 = 1'b1; sel1 = 2'b10; {a0, a1, a2, a3} = 4'b0010;
        @(negedge clk);
        tests++;
        if (out_q1 !== 1'b1 || out_vld1 !== 1'b1) begin
            fails++;
            $display("FAIL reg_capture got q=%0b vld=%0b exp q=1 vld=1", out_q1, out_vld1);
        end
        en1 = 1'b0; a2 = 1'b0;
        #1;
        tests++;
        if (out1 !== 1'b0) begin
            fails++;
            $display("FAIL reg_out_immediate got %0b exp 0", out1);
        end
        @(negedge clk);
        tests++;
        if (out_q1 !== 1'b1 || out_vld1 !== 1'b0) begin
            fails++;
            $display("FAIL reg_hold got q=%0b vld=%0b exp q=1 vld=0", out_q1, out_vld1);
        end
    endtask

    task automatic test_saturation();
        cnt_clr1 = 1'b1;
        @(negedge clk);
        cnt_clr1 = 1'b0;
        en1 = 1'b1; sel1 = 2'b01; {a0, a1, a2, a3} = 4'b0100;
        rd_sel1 = 2'b01;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (cnt1 !== 2'd2) begin
            fails++;
            $display("FAIL sat_after2 got %0d exp 2", cnt1);
        end
        repeat (3) @(negedge clk);
        en1 = 1'b0;
        #1;
        tests++;
        if (cnt1 !== 2'd3) begin
            fails++;
            $display("FAIL sat_no_wrap got %0d exp 3", cnt1);
        end
        rd_sel1 = 2'b00;
        #1;
        tests++;
        if (cnt1 !== 2'd0) begin
            fails++;
            $display("FAIL sat_other_cnt got %0d exp 0", cnt1);
        end
    endtask

    task automatic test_priority();
        // counter 1 sits at 3, out_q=1 from the saturation run
        @(negedge clk);
        cnt_clr1 = 1'b1; en1 = 1'b1; sel1 = 2'b11; a3 = 1'b1;
        @(negedge clk);
        cnt_clr1 = 1'b0; en1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_sel1 = 2'(i);
            #1;
            tests++;
            if (cnt1 !== 2'd0) begin
                fails++;
                $display("FAIL prio_clr_cnt%0d got %0d exp 0", i, cnt1);
            end
        end
        tests++;
        if (out_q1 !== 1'b1 || out_vld1 !== 1'b1) begin
            fails++;
            $display("FAIL prio_clr_keeps_q got q=%0b vld=%0b exp q=1 vld=1", out_q1, out_vld1);
        end
        @(negedge clk);
        en1 = 1'b1; sel1 = 2'b00; {a0, a1, a2, a3} = 4'b1000; rd_sel1 = 2'b00;
        @(negedge clk);
        tests++;
        if (cnt1 !== 2'd1) begin
            fails++;
            $display("FAIL prio_inc_after_clr got %0d exp 1", cnt1);
        end
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0; en1 = 1'b0;
        #1;
        tests++;
        if (out_q1 !== 1'b0 || out_vld1 !== 1'b0) begin
            fails++;
            $display("FAIL prio_rst_over_en got q=%0b vld=%0b exp q=0 vld=0", out_q1, out_vld1);
        end
        tests++;
        if (cnt1 !== 2'd0) begin
            fails++;
            $display("FAIL prio_rst_cnt got %0d exp 0", cnt1);
        end
        tests++;
        if (out1 !== 1'b1) begin
            fails++;
            $display("FAIL prio_rst_out_tracks got %0b exp 1", out1);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q, exp_out;
        logic       exp_vld;
        logic [7:0] mcnt [4];
        logic [7:0] ins [4];
        exp_q = '0;
        exp_vld = 1'b0;
        for (int i = 0; i < 4; i++) mcnt[i] = '0;
        @(negedge clk);
        for (int c = 0; c < 1000; c++) begin
            if (c > 0) begin
                tests++;
                if (out_vld8 !== exp_vld) begin
                    fails++;
                    $display("FAIL rand_vld cyc %0d got %0b exp %0b", c, out_vld8, exp_vld);
                end
                tests++;
                if (out_q8 !== exp_q) begin
                    fails++;
                    $display("FAIL rand_out_q cyc %0d got %0h exp %0h", c, out_q8, exp_q);
                end
            end
            rd_sel8 = 2'($urandom_range(0, 3));
            #1;
            tests++;
            if (cnt8 !== mcnt[rd_sel8]) begin
                fails++;
                $display("FAIL rand_cnt cyc %0d idx %0d got %0d exp %0d", c, rd_sel8, cnt8, mcnt[rd_sel8]);
            end
            rst8 = 1'b0;
            sel8 = 2'($urandom_range(0, 3));
            en8  = 1'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++) ins[k] = 8'($urandom_range(0, 255));
            b0 = ins[0]; b1 = ins[1]; b2 = ins[2]; b3 = ins[3];
            exp_out = ins[sel8];
            #1;
            tests++;
            if (out8 !== exp_out) begin
                fails++;
                $display("FAIL rand_out cyc %0d sel %0d got %0h exp %0h", c, sel8, out8, exp_out);
            end
            exp_vld = en8;
            if (en8) begin
                exp_q = exp_out;
                if (mcnt[sel8] != 8'hFF) mcnt[sel8] = mcnt[sel8] + 8'd1;
            end
            @(negedge clk);
        end
        en8 = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst1 = 1'b1; en1 = 1'b0; cnt_clr1 = 1'b0; sel1 = 2'b00; rd_sel1 = 2'b00;
        a0 = 1'b0; a1 = 1'b0; a2 = 1'b0; a3 = 1'b0;
        rst8 = 1'b1; en8 = 1'b0; cnt_clr8 = 1'b0; sel8 = 2'b00; rd_sel8 = 2'b00;
        b0 = '0; b1 = '0; b2 = '0; b3 = '0;

        test_reset();
        test_onehot();
        test_inverse();
        test_registered();
        test_saturation();
        test_priority();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
